mux_8_1: RTL and testbench
==========================

// Module: mux_8_1
// PURPOSE
//   8:1 word multiplexer: forwards one of eight WIDTH-bit inputs to out, chosen by a 3-bit select.
//   Leaf datapath block of the single-cycle processor.
//   Used in pairs under the 16:1 register-file read mux; the upper select bit feeds a mux2_1.
//   Built only from 2:1 mux cells so gate delays stay explicit.
// PARAMETERS
//   WIDTH    64    bit width of every data input and of out
// PORTS
//   clk      in    1               system clock; used only when MUX_8_1_OUT_REG_EN is defined
//   rst_n    in    1               asynchronous, active-low reset; used only with MUX_8_1_OUT_REG_EN
//   i        in    [7:0][WIDTH-1:0] packed data inputs; i[k] is selected when sel==k
//   sel      in    3               binary select, sel[0] = LSB
//   out      out   WIDTH           selected word
// BEHAVIOUR
//   - One clock; reset is asynchronous and active-low.
//   - Default build (macro undefined):
//     - purely combinational, out = i[sel], zero latency;
//     - clk and rst_n are ignored; no reset value applies.
//   - Select decoding: sel=000 -> i[0], ... sel=111 -> i[7].
//     - All 8 codes are legal; no out-of-range case exists.
//   - Any change on i[sel] or sel propagates to out without a clock edge.
//     - Non-selected inputs have no effect on out.
//   - X/Z on a sel bit may drive out to X. Once sel is fully known, out is fully defined.
//   - Width rule: no truncation or extension; every out bit is an independent copy of the same bit of the selected input.
// CONFIGURATION
//   MUX_8_1_OUT_REG_EN
//   - Undefined: combinational behaviour as above.
//   - Defined: out is a flop stage.
//     - Each rising clk: out <= i[sel] sampled at that edge; latency is 1 cycle.
//     - rst_n low clears out to 0 immediately (asynchronous), with no wait for clk.
//     - Release of rst_n is synchronous to clk.
//     - First valid word appears on the first rising edge after release.
//     - If rst_n asserts mid-operation, out = 0 while low; prior data is discarded.
// STRUCTURE
//   - Shared package mux_pkg: default WIDTH constant (64); typedef logic [WIDTH-1:0] word_t.
//   - Sub-module mux2_1 (ports i0, i1, sel, out; out = sel ? i1 : i0), per-bit generate of AND/OR/NOT gates.
//   - Tree of 7 mux2_1 instances:
//     - level 0: 4 muxes on sel[0], pairs (i0,i1)..(i6,i7);
//     - level 1: 2 muxes on sel[1];
//     - level 2: 1 mux on sel[2].
//   - Optional output register, in an ifdef block, sits after level 2.
// TESTING
//   Bench drives i[0..7] = 64357, 26000, 24556, 12328, 63, 31, 132346, 7, holding each step 10 ns.
//   1. Sweep: sel 000..111 in order -> out = 64357, 26000, 24556, 12328, 63, 31, 132346, 7.
//   2. Isolation: sel=011; change i[2] to 64'hFFFF_FFFF_FFFF_FFFF -> out stays 12328.
//      Then change i[3] to 5 -> out = 5.
//   3. Full width: i[7]=64'h8000_0000_0000_0001, sel=111 -> out = 64'h8000_0000_0000_0001.
//      Checks the MSB and LSB both pass.
//   4. Select glitch: toggle sel 000<->111 every 10 ns -> out alternates 64357/7 with no stale value.
//   5. MUX_8_1_OUT_REG_EN:
//      - rst_n=0 -> out=0 with no clk edge;
//      - release, sel=110 -> out=132346 one edge later;
//      - assert rst_n mid-run -> out=0 at once.
//   Mismatches are reported with $display naming sel, expected value and actual value.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared definitions for the word multiplexers of the single-cycle datapath.
package mux_pkg;

    localparam int MUX_WIDTH = 64;

    typedef logic [MUX_WIDTH-1:0] word_t;

endpackage

// File: rtl/mux2_1.sv
// 2:1 word mux built from explicit per-bit AND/OR/NOT gates: out = sel ? i1 : i0.
module mux2_1
    import mux_pkg::*;
#(
    parameter int WIDTH = MUX_WIDTH
) (
    input  logic [WIDTH-1:0] i0,
    input  logic [WIDTH-1:0] i1,
    input  logic             sel,
    output logic [WIDTH-1:0] out
);

    logic sel_n;

    assign sel_n = ~sel;

    for (genvar b = 0; b < WIDTH; b++) begin : g_bit
        assign out[b] = (i0[b] & sel_n) | (i1[b] & sel);
    end

endmodule

// File: rtl/mux_8_1.sv
// 8:1 word mux as a three-level tree of mux2_1 cells (sel[0], sel[1], sel[2]).
// Define MUX_8_1_OUT_REG_EN to register the output with an async active-low clear.
module mux_8_1
    import mux_pkg::*;
#(
    parameter int WIDTH = MUX_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [7:0][WIDTH-1:0] i,
    input  logic [2:0]            sel,
    output logic [WIDTH-1:0]      out
);

    logic [WIDTH-1:0] lvl0 [4];
    logic [WIDTH-1:0] lvl1 [2];
    logic [WIDTH-1:0] lvl2;

    for (genvar k = 0; k < 4; k++) begin : g_lvl0
        mux2_1 #(.WIDTH(WIDTH)) u_mux (
            .i0  (i[2*k]),
            .i1  (i[2*k+1]),
            .sel (sel[0]),
            .out (lvl0[k])
        );
    end

    for (genvar k = 0; k < 2; k++) begin : g_lvl1
        mux2_1 #(.WIDTH(WIDTH)) u_mux (
            .i0  (lvl0[2*k]),
            .i1  (lvl0[2*k+1]),
            .sel (sel[1]),
            .out (lvl1[k])
        );
    end

    mux2_1 #(.WIDTH(WIDTH)) u_lvl2 (
        .i0  (lvl1[0]),
        .i1  (lvl1[1]),
        .sel (sel[2]),
        .out (lvl2)
    );

`ifdef MUX_8_1_OUT_REG_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out <= '0;
        end else begin
            out <= lvl2;
        end
    end
`else
    // Combinational build: clk and rst_n are intentionally inert.
    logic unused_ok;

    assign unused_ok = ^{clk, rst_n};
    assign out       = lvl2;
`endif

endmodule

// File: tb/tb_mux_8_1.sv
// Self-checking bench for mux_8_1; covers both the combinational and registered builds.
module tb_mux_8_1;
    import mux_pkg::*;

    localparam int W = MUX_WIDTH;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic [7:0][W-1:0] i_bus;
    logic [2:0]       sel;
    logic [W-1:0]     out;

    word_t            mdl [8];
    logic [W-1:0]     exp_q [$];
    logic [W-1:0]     exp_v;
    logic [W-1:0]     got;
    int               n_vec = 0;
    int               n_err = 0;

    mux_8_1 #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .i     (i_bus),
        .sel   (sel),
        .out   (out)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic load_table;
        mdl[0] = 64'd64357;
        mdl[1] = 64'd26000;
        mdl[2] = 64'd24556;
        mdl[3] = 64'd12328;
        mdl[4] = 64'd63;
        mdl[5] = 64'd31;
        mdl[6] = 64'd132346;
        mdl[7] = 64'd7;
    endtask

    task automatic apply_inputs;
        for (int k = 0; k < 8; k++) i_bus[k] = mdl[k];
    endtask

    // Drives one step just after a falling edge, queues the expected word,
    // then waits until out should reflect it.
    task automatic drive_step(input logic [2:0] s);
        @(negedge clk);
        apply_inputs();
        sel = s;
        exp_q.push_back(mdl[s]);
`ifdef MUX_8_1_OUT_REG_EN
        @(posedge clk);
        #1;
`else
        #2;
`endif
    endtask

    // ---------------- tests ----------------
    task automatic test_reset;
        load_table();
        @(negedge clk);
        apply_inputs();
        sel   = 3'd2;
        rst_n = 1'b0;
        #1;
`ifdef MUX_8_1_OUT_REG_EN
        exp_v = '0;
`else
        exp_v = mdl[2];
`endif
        got = out;
        n_vec++;
        if (got !== exp_v) begin
            n_err++;
            $display("FAIL reset: sel=%0d expected=%0d actual=%0d", sel, exp_v, got);
        end
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_sweep;
        load_table();
        for (int s = 0; s < 8; s++) begin
            drive_step(3'(s));
            got   = out;
            exp_v = exp_q.pop_front();
            n_vec++;
            if (got !== exp_v) begin
                n_err++;
                $display("FAIL sweep: sel=%0d expected=%0d actual=%0d", sel, exp_v, got);
            end
        end
    endtask

    task automatic test_isolation;
        load_table();
        for (int step = 0; step < 3; step++) begin
            if (step == 1) mdl[2] = 64'hFFFF_FFFF_FFFF_FFFF;
            if (step == 2) mdl[3] = 64'd5;
            drive_step(3'd3);
            got   = out;
            exp_v = exp_q.pop_front();
            n_vec++;
            if (got !== exp_v) begin
                n_err++;
                $display("FAIL isolation step %0d: sel=%0d expected=%0d actual=%0d",
                         step, sel, exp_v, got);
            end
        end
    endtask

    task automatic test_full_width;
        load_table();
        mdl[7] = 64'h8000_0000_0000_0001;
        drive_step(3'd7);
        got   = out;
        exp_v = exp_q.pop_front();
        n_vec++;
        if (got !== exp_v) begin
            n_err++;
            $display("FAIL full_width: sel=%0d expected=%h actual=%h", sel, exp_v, got);
        end
    endtask

    task automatic test_select_glitch;
        load_table();
        for (int n = 0; n < 10; n++) begin
            drive_step((n % 2 == 0) ? 3'd0 : 3'd7);
            got   = out;
            exp_v = exp_q.pop_front();
            n_vec++;
            if (got !== exp_v) begin
                n_err++;
                $display("FAIL select_glitch: sel=%0d expected=%0d actual=%0d", sel, exp_v, got);
            end
        end
    endtask

    task automatic test_random;
        int unsigned other;
        for (int n = 0; n < 150; n++) begin
            for (int k = 0; k < 8; k++) mdl[k] = {$urandom, $urandom};
            drive_step(3'($urandom_range(0, 7)));
            got   = out;
            exp_v = exp_q.pop_front();
            n_vec++;
            if (got !== exp_v) begin
                n_err++;
                $display("FAIL random: sel=%0d expected=%h actual=%h", sel, exp_v, got);
            end
            // Disturb a non-selected input; out must not move.
            other = (32'(sel) + $urandom_range(1, 7)) % 8;
            mdl[other] = {$urandom, $urandom};
            apply_inputs();
            #1;
            got = out;
            n_vec++;
            if (got !== exp_v) begin
                n_err++;
                $display("FAIL random_isolation: sel=%0d changed=%0d expected=%h actual=%h",
                         sel, other, exp_v, got);
            end
        end
    endtask

`ifdef MUX_8_1_OUT_REG_EN
    task automatic test_reg_reset;
        load_table();
        // Hold reset, then release with sel=110; the word lands one edge later.
        @(negedge clk);
        rst_n = 1'b0;
        apply_inputs();
        sel = 3'd6;
        #1;
        got = out;
        n_vec++;
        if (got !== '0) begin
            n_err++;
            $display("FAIL reg_reset_hold: sel=%0d expected=0 actual=%0d", sel, got);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        got = out;
        n_vec++;
        if (got !== '0) begin
            n_err++;
            $display("FAIL reg_release_no_edge: sel=%0d expected=0 actual=%0d", sel, got);
        end
        @(posedge clk);
        #1;
        got = out;
        n_vec++;
        if (got !== mdl[6]) begin
            n_err++;
            $display("FAIL reg_first_word: sel=%0d expected=%0d actual=%0d", sel, mdl[6], got);
        end
        // Mid-run assertion clears out between edges.
        #2;
        rst_n = 1'b0;
        #1;
        got = out;
        n_vec++;
        if (got !== '0) begin
            n_err++;
            $display("FAIL reg_mid_reset: sel=%0d expected=0 actual=%0d", sel, got);
        end
        @(posedge clk);
        #1;
        got = out;
        n_vec++;
        if (got !== '0) begin
            n_err++;
            $display("FAIL reg_reset_held_edge: sel=%0d expected=0 actual=%0d", sel, got);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask
`endif

    // ---------------- sequence and report ----------------
    initial begin
        load_table();
        apply_inputs();
        sel = 3'd0;
        repeat (2) @(posedge clk);
        test_reset();
        test_sweep();
        test_isolation();
        test_full_width();
        test_select_glitch();
        test_random();
`ifdef MUX_8_1_OUT_REG_EN
        test_reg_reset();
`endif
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL scoreboard: leftover expected=%0d actual=%0d", 0, exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
